// File: rtl/fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack port plus decoder-side valid/ready issue port.
// master = fetch unit, slave = memory/decoder environment.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc_plus4;
  logic        branch;
  logic        zero;
  logic        jump;
  logic [31:0] instr_count;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, op, funct, pc_plus4, instr_count,
    input  imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, op, funct, pc_plus4, instr_count,
    output imem_ack, imem_rdata, instr_ready, branch, zero, jump
  );
endinterface

// File: rtl/fetch_unit.sv
// Two-state instruction fetch: ack in cycle N gives instr_valid in N+1, so at least 2 cycles per instruction.
// Backpressure: instr_ready=0 holds the issued instruction indefinitely; memory waits by withholding imem_ack.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master bus
);

  typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] count_q;
  logic [31:0] pc_plus4;
  logic [31:0] br_off;
  logic [31:0] jump_tgt;
  logic [31:0] pc_nxt;
  logic        req_raw;
  logic        valid_raw;
  logic        take_ack;
  logic        fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_raw   = 1'b0;
    valid_raw = 1'b0;
    case (state)
      FETCH: begin
        req_raw = 1'b1;
        if (bus.imem_ack) state_nxt = ISSUE;
      end
      ISSUE: begin
        valid_raw = 1'b1;
        if (bus.instr_ready) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  assign take_ack = (state == FETCH) && bus.imem_ack;
  assign fire     = (state == ISSUE) && bus.instr_ready;

  assign pc_plus4 = pc + 32'd4;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_tgt = {pc_plus4[31:28], instr_q[25:0], 2'b00};

  // Jump wins over a taken branch; an untaken branch falls through.
  always_comb begin
    pc_nxt = pc_plus4;
    if (bus.jump)                      pc_nxt = jump_tgt;
    else if (bus.branch && bus.zero)   pc_nxt = pc_plus4 + br_off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr_q <= 32'h0;
      count_q <= 32'h0;
    end else begin
      if (take_ack) instr_q <= bus.imem_rdata;
      if (fire) begin
        pc      <= pc_nxt;
        count_q <= count_q + 32'd1;
      end
    end
  end

  // Request is masked by reset so it drops immediately, not at the next edge.
  assign bus.imem_req    = req_raw && rst_n;
  assign bus.instr_valid = valid_raw;
  assign bus.imem_addr   = pc;
  assign bus.instr       = instr_q;
  assign bus.op          = instr_q[31:26];
  assign bus.funct       = instr_q[5:0];
  assign bus.pc_plus4    = pc_plus4;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Three fetch units (RESET_PC 0, FFFF_FFFC, 4000_0000) driven in lockstep, checked against a PC/count model.
module tb_fetch_unit;
  logic clk;
  logic rst_n;

  fetch_unit_if bus_a ();
  fetch_unit_if bus_b ();
  fetch_unit_if bus_c ();

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  fetch_unit #(.RESET_PC(32'h4000_0000)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  assign bus_b.imem_ack    = bus_a.imem_ack;
  assign bus_b.imem_rdata  = bus_a.imem_rdata;
  assign bus_b.instr_ready = bus_a.instr_ready;
  assign bus_b.branch      = bus_a.branch;
  assign bus_b.zero        = bus_a.zero;
  assign bus_b.jump        = bus_a.jump;
  assign bus_c.imem_ack    = bus_a.imem_ack;
  assign bus_c.imem_rdata  = bus_a.imem_rdata;
  assign bus_c.instr_ready = bus_a.instr_ready;
  assign bus_c.branch      = bus_a.branch;
  assign bus_c.zero        = bus_a.zero;
  assign bus_c.jump        = bus_a.jump;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] RST_PC [3] = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h4000_0000};

  typedef struct {
    logic [31:0] ins;
    int          waits;
    int          stall;
    logic        b;
    logic        z;
    logic        j;
    logic [31:0] exp_next;
  } vec_t;

  vec_t        tbl [7];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mpc [3];
  logic [31:0] mcnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Architectural next-PC rule, from the instruction-set definition.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] ins,
                                             input logic b, input logic z, input logic j);
    logic [31:0]        p4;
    logic signed [15:0] imm;
    int                 off;
    p4  = pc + 32'd4;
    imm = ins[15:0];
    off = imm;
    if (j)           return {p4[31:28], ins[25:0], 2'b00};
    else if (b && z) return p4 + 32'(off * 4);
    else             return p4;
  endfunction

  task automatic check_fetch(input string tag);
    chk({tag, "_req_a"},  32'(bus_a.imem_req), 32'd1);
    chk({tag, "_req_b"},  32'(bus_b.imem_req), 32'd1);
    chk({tag, "_req_c"},  32'(bus_c.imem_req), 32'd1);
    chk({tag, "_addr_a"}, bus_a.imem_addr, mpc[0]);
    chk({tag, "_addr_b"}, bus_b.imem_addr, mpc[1]);
    chk({tag, "_addr_c"}, bus_c.imem_addr, mpc[2]);
    chk({tag, "_vld_a"},  32'(bus_a.instr_valid), 32'd0);
    chk({tag, "_cnt_a"},  bus_a.instr_count, mcnt);
    chk({tag, "_cnt_c"},  bus_c.instr_count, mcnt);
  endtask

  task automatic check_issue(input string tag, input logic [31:0] ins);
    chk({tag, "_vld_a"},   32'(bus_a.instr_valid), 32'd1);
    chk({tag, "_vld_b"},   32'(bus_b.instr_valid), 32'd1);
    chk({tag, "_req_a"},   32'(bus_a.imem_req), 32'd0);
    chk({tag, "_req_c"},   32'(bus_c.imem_req), 32'd0);
    chk({tag, "_instr_a"}, bus_a.instr, ins);
    chk({tag, "_op_a"},    32'(bus_a.op), 32'(ins[31:26]));
    chk({tag, "_funct_a"}, 32'(bus_a.funct), 32'(ins[5:0]));
    chk({tag, "_p4_a"},    bus_a.pc_plus4, mpc[0] + 32'd4);
    chk({tag, "_p4_b"},    bus_b.pc_plus4, mpc[1] + 32'd4);
    chk({tag, "_p4_c"},    bus_c.pc_plus4, mpc[2] + 32'd4);
    chk({tag, "_addr_a"},  bus_a.imem_addr, mpc[0]);
    chk({tag, "_cnt_a"},   bus_a.instr_count, mcnt);
  endtask

  // One full fetch/issue/consume transaction; entered and left #1 after an edge in FETCH.
  task automatic do_instr(input logic [31:0] ins, input int waits, input int stall,
                          input logic b, input logic z, input logic j);
    check_fetch("fetch");
    for (int w = 0; w < waits; w++) begin
      bus_a.imem_ack    = 1'b0;
      bus_a.imem_rdata  = $urandom;
      bus_a.instr_ready = 1'($urandom);
      tick;
      check_fetch("wait");
    end
    bus_a.imem_ack    = 1'b1;
    bus_a.imem_rdata  = ins;
    bus_a.instr_ready = 1'($urandom);
    tick;
    bus_a.imem_ack    = 1'b0;
    bus_a.instr_ready = 1'b0;
    check_issue("issue", ins);
    for (int s = 0; s < stall; s++) begin
      bus_a.imem_ack   = 1'($urandom);
      bus_a.imem_rdata = $urandom;
      bus_a.branch     = 1'($urandom);
      bus_a.zero       = 1'($urandom);
      bus_a.jump       = 1'($urandom);
      tick;
      check_issue("stall", ins);
    end
    bus_a.imem_ack    = 1'b0;
    bus_a.branch      = b;
    bus_a.zero        = z;
    bus_a.jump        = j;
    bus_a.instr_ready = 1'b1;
    tick;
    bus_a.instr_ready = 1'b0;
    bus_a.branch      = 1'b0;
    bus_a.zero        = 1'b0;
    bus_a.jump        = 1'b0;
    for (int k = 0; k < 3; k++) mpc[k] = model_next(mpc[k], ins, b, z, j);
    mcnt = mcnt + 32'd1;
  endtask

  // Asynchronous reset mid-cycle, optionally with a colliding imem_ack.
  task automatic do_reset(input logic ack_during);
    #2;
    rst_n          = 1'b0;
    bus_a.imem_ack = ack_during;
    #1;
    chk("rst_vld_a",   32'(bus_a.instr_valid), 32'd0);
    chk("rst_vld_c",   32'(bus_c.instr_valid), 32'd0);
    chk("rst_req_a",   32'(bus_a.imem_req), 32'd0);
    chk("rst_req_b",   32'(bus_b.imem_req), 32'd0);
    chk("rst_cnt_a",   bus_a.instr_count, 32'd0);
    chk("rst_instr_a", bus_a.instr, 32'd0);
    chk("rst_addr_b",  bus_b.imem_addr, RST_PC[1]);
    tick;
    tick;
    #2;
    rst_n          = 1'b1;
    bus_a.imem_ack = 1'b0;
    for (int k = 0; k < 3; k++) mpc[k] = RST_PC[k];
    mcnt = 32'd0;
    tick;
    check_fetch("rel");
    chk("rel_instr_a", bus_a.instr, 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h8C08_0004, 3, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0004};
    tbl[1] = '{32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0008};
    tbl[2] = '{32'h0800_0004, 1, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
    tbl[3] = '{32'h1000_FFFE, 0, 2, 1'b1, 1'b1, 1'b0, 32'h0000_000C};
    tbl[4] = '{32'h0800_0004, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0010};
    tbl[5] = '{32'h1000_FFFE, 2, 0, 1'b1, 1'b0, 1'b0, 32'h0000_0014};
    tbl[6] = '{32'h0800_0100, 0, 5, 1'b1, 1'b1, 1'b1, 32'h0000_0400};

    rst_n             = 1'b1;
    bus_a.imem_ack    = 1'b0;
    bus_a.imem_rdata  = 32'h0;
    bus_a.instr_ready = 1'b0;
    bus_a.branch      = 1'b0;
    bus_a.zero        = 1'b0;
    bus_a.jump        = 1'b0;
    mcnt              = 32'd0;
    for (int k = 0; k < 3; k++) mpc[k] = RST_PC[k];
    do_reset(1'b1);

    for (int i = 0; i < 7; i++) begin
      do_instr(tbl[i].ins, tbl[i].waits, tbl[i].stall, tbl[i].b, tbl[i].z, tbl[i].j);
      chk($sformatf("tbl%0d_next", i), bus_a.imem_addr, tbl[i].exp_next);
      if (i == 2) chk("tbl_cnt3", bus_a.instr_count, 32'd3);
    end

    // Reset while an instruction is being issued.
    check_fetch("mid");
    bus_a.imem_ack   = 1'b1;
    bus_a.imem_rdata = 32'hDEAD_BEEF;
    tick;
    bus_a.imem_ack   = 1'b0;
    check_issue("mid_issue", 32'hDEAD_BEEF);
    do_reset(1'b1);
    chk("mid_rel_addr_a", bus_a.imem_addr, 32'h0000_0000);
    chk("mid_rel_cnt_a",  bus_a.instr_count, 32'd0);

    // RESET_PC at the top of memory: second fetch wraps to 0.
    do_instr(32'h0000_0020, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("wrap_b_2nd_addr", bus_b.imem_addr, 32'h0000_0000);

    // Jump from 0x4000_0000 overriding a taken branch.
    do_reset(1'b0);
    do_instr(32'h0800_0100, 1, 5, 1'b1, 1'b1, 1'b1);
    chk("jmp_c_addr", bus_c.imem_addr, 32'h4000_0400);
    chk("jmp_b_addr", bus_b.imem_addr, 32'h0000_0400);

    for (int r = 0; r < 40; r++) begin
      do_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
    end
    check_fetch("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
